// File: rtl/rs232_rx_deframer_if.sv
// rs232_rx_deframer_if: serial line, byte stream handshake and status of the RS232 receive deframer
interface rs232_rx_deframer_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  modport master (input rx, rx_ready, output rx_data, rx_valid, frame_err, overrun, busy);
  modport slave  (output rx, rx_ready, input rx_data, rx_valid, frame_err, overrun, busy);
endinterface

// File: rtl/rs232_rx_deframer.sv
// rs232_rx_deframer: recovers 8N1 frames from the rx line into a 1-byte valid/ready holding register
module rs232_rx_deframer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  rs232_rx_deframer_if.master  bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [2:0]             idx;
  logic [7:0]             shreg;
  assign rx_s = sync[SYNC_STAGES-1];
  // metastability synchroniser for the asynchronous rx line, idles high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '1;
    else sync <= {sync[SYNC_STAGES-2:0], bus.rx};
  // frame FSM: mid-bit sampling, byte delivery into the holding register, error pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            state    <= START;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        START:
          if (cnt == HALF_M1) begin
            cnt <= '0;
            idx <= '0;
            if (rx_s) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end else state <= DATA;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              if (!bus.rx_valid || bus.rx_ready) begin
                bus.rx_data  <= shreg;
                bus.rx_valid <= 1'b1;
              end else bus.overrun <= 1'b1;
            end else begin
              state         <= BRK;
              bus.frame_err <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        BRK:
          if (rx_s) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_rs232_rx_deframer.sv
// tb_rs232_rx_deframer: directed frames with a scoreboard popped on every accepted byte
module tb_rs232_rx_deframer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   vcnt, fe_cnt, ov_cnt, rise_cyc, ov_cyc, t0, t1;
  logic prev_v = 1'b0;
  logic [7:0] q[$];
  rs232_rx_deframer_if bus ();
  rs232_rx_deframer #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic hold(input int n);
    repeat (n) tick();
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    bus.rx = 1'b0;
    hold(8);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      hold(8);
    end
    bus.rx = stop;
    hold(8);
  endtask
  task automatic clr();
    vcnt = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    rise_cyc = 0;
    ov_cyc = 0;
  endtask
  // monitor: samples on the falling edge, pops the scoreboard on every valid&ready transfer
  always @(negedge clk)
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (bus.rx_valid && !prev_v) rise_cyc = cyc;
      prev_v = bus.rx_valid;
      if (bus.rx_valid) vcnt++;
      if (bus.frame_err) fe_cnt++;
      if (bus.overrun) begin
        ov_cnt++;
        ov_cyc = cyc;
      end
      if (bus.frame_err || bus.overrun) chk("flags_exclusive", int'(bus.frame_err & bus.overrun), 0);
      if (bus.rx_valid && bus.rx_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h required=none", bus.rx_data);
        end else chk("sb_data", int'(bus.rx_data), int'(q.pop_front()));
      end
    end
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
  initial begin
    bus.rx = 1'b1;
    bus.rx_ready = 1'b0;
    clr();
    hold(3);
    chk("rst_data", int'(bus.rx_data), 0);
    chk("rst_valid", int'(bus.rx_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ferr", int'(bus.frame_err), 0);
    chk("rst_ovr", int'(bus.overrun), 0);
    rst_n = 1'b1;
    hold(4);
    // 1: single byte, consumer always ready
    bus.rx_ready = 1'b1;
    clr();
    q.push_back(8'hA5);
    t0 = cyc;
    send(8'hA5, 1'b1);
    hold(8);
    chk("t1_latency", rise_cyc - t0, 79);
    chk("t1_valid_cycles", vcnt, 1);
    chk("t1_ferr", fe_cnt, 0);
    chk("t1_ovr", ov_cnt, 0);
    chk("t1_busy", int'(bus.busy), 0);
    // 2: short low glitch
    clr();
    bus.rx = 1'b0;
    hold(3);
    bus.rx = 1'b1;
    chk("t2_busy_hi", int'(bus.busy), 1);
    hold(6);
    chk("t2_busy_lo", int'(bus.busy), 0);
    hold(10);
    chk("t2_valid", vcnt, 0);
    chk("t2_ferr", fe_cnt, 0);
    // 3: stop bit low then break, then recovery
    clr();
    send(8'h3C, 1'b0);
    hold(40);
    chk("t3_ferr", fe_cnt, 1);
    chk("t3_valid", vcnt, 0);
    chk("t3_busy_break", int'(bus.busy), 1);
    bus.rx = 1'b1;
    hold(16);
    q.push_back(8'h5A);
    send(8'h5A, 1'b1);
    hold(8);
    chk("t3_ferr_after", fe_cnt, 1);
    chk("t3_valid_after", vcnt, 1);
    // 4: back-to-back bytes with consumer stalled
    bus.rx_ready = 1'b0;
    clr();
    q.push_back(8'h11);
    send(8'h11, 1'b1);
    t1 = cyc;
    send(8'h22, 1'b1);
    hold(4);
    chk("t4_ovr", ov_cnt, 1);
    chk("t4_ovr_time", ov_cyc - t1, 79);
    chk("t4_data", int'(bus.rx_data), 8'h11);
    chk("t4_valid", int'(bus.rx_valid), 1);
    chk("t4_ferr", fe_cnt, 0);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    tick();
    chk("t4_drained", int'(bus.rx_valid), 0);
    hold(8);
    // 5: consumer ready only in the second stop-sample cycle
    clr();
    q.push_back(8'h11);
    send(8'h11, 1'b1);
    t1 = cyc;
    fork
      send(8'h22, 1'b1);
      begin
        hold(78);
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
      end
    join
    hold(4);
    chk("t5_data", int'(bus.rx_data), 8'h22);
    chk("t5_valid", int'(bus.rx_valid), 1);
    chk("t5_ovr", ov_cnt, 0);
    // 6: asynchronous reset in the middle of a frame, 8'h22 still held
    clr();
    bus.rx = 1'b0;
    hold(8);
    bus.rx = 1'b1;
    hold(20);
    chk("t6_busy_pre", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_data", int'(bus.rx_data), 0);
    chk("t6_valid", int'(bus.rx_valid), 0);
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_ferr", int'(bus.frame_err), 0);
    chk("t6_ovr", int'(bus.overrun), 0);
    hold(3);
    rst_n = 1'b1;
    hold(16);
    bus.rx_ready = 1'b1;
    clr();
    q.push_back(8'h7E);
    send(8'h7E, 1'b1);
    hold(8);
    chk("t6_valid_after", vcnt, 1);
    chk("t6_ferr_after", fe_cnt, 0);
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
